// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix pins plus the debounced key event bundle
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       key_en;
    logic [3:0] key_index;
    logic       key_down;

    modport master (input col_n, output row_n, key_en, key_index, key_down);
    modport slave  (output col_n, input row_n, key_en, key_index, key_down);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with press/release debounce; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_TICKS = 8'd4,
    parameter logic [7:0]  REPEAT_TICKS   = 8'd100
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  col_m, col_s;
    logic [15:0] div_q;
    logic        tick;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  row_q, row_d, row_rot;
    logic [1:0]  cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [1:0]  enc_col, enc_row;
    logic        any_low;
    logic        key_en_q, key_en_d;
    logic [3:0]  key_index_q, key_index_d;
`ifdef KEYPAD_REPEAT_EN
    logic [7:0]  rep_q, rep_d;
`else
    // No repeat logic in this build; the parameter stays for a uniform instantiation.
    if (REPEAT_TICKS == 8'd0) begin : g_no_repeat
    end
`endif

    assign tick    = (div_q == SCAN_DIV - 16'd1);
    assign any_low = (col_s != 4'hF);
    assign row_rot = {row_q[2:0], row_q[3]};

    // Lowest-index active line wins for both columns and the driven row.
    always_comb begin
        enc_col = 2'd0;
        enc_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) enc_col = 2'(i);
            if (!row_q[i]) enc_row = 2'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        key_en_d    = 1'b0;
        key_index_d = key_index_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!any_low) begin
                        row_d = row_rot;
                    end else begin
                        cur_row_d = enc_row;
                        cur_col_d = enc_col;
                        cnt_d     = 8'd0;
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && enc_col == cur_col_q) begin
                        if (cnt_q == DEBOUNCE_TICKS - 8'd1) begin
                            key_index_d = {cur_row_q, cur_col_q};
                            key_en_d    = 1'b1;
                            state_d     = HOLD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = 8'd0;
`endif
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    if (!any_low) begin
                        cnt_d   = 8'd0;
                        state_d = RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q == REPEAT_TICKS - 8'd1) begin
                        rep_d    = 8'd0;
                        key_en_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 8'd1;
                    end
`endif
                end
                RELEASE: begin
                    if (!any_low) begin
                        if (cnt_q == DEBOUNCE_TICKS - 8'd1) begin
                            state_d = SCAN;
                            row_d   = row_rot;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = 8'd0;
`endif
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m       <= 4'hF;
            col_s       <= 4'hF;
            div_q       <= 16'd0;
            state_q     <= SCAN;
            cnt_q       <= 8'd0;
            row_q       <= 4'b1110;
            cur_row_q   <= 2'd0;
            cur_col_q   <= 2'd0;
            key_en_q    <= 1'b0;
            key_index_q <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= 8'd0;
`endif
        end else begin
            col_m       <= kp.col_n;
            col_s       <= col_m;
            div_q       <= tick ? 16'd0 : div_q + 16'd1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            key_en_q    <= key_en_d;
            key_index_q <= key_index_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign kp.row_n     = row_q;
    assign kp.key_en    = key_en_q;
    assign kp.key_index = key_index_q;
    assign kp.key_down  = (state_q == HOLD) || (state_q == RELEASE);
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a keypad matrix and key event model
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD = 8;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REP_PULSES = 5;
`else
    localparam int EXP_REP_PULSES = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV(16'd8), .DEBOUNCE_TICKS(8'd3), .REPEAT_TICKS(8'd5)
    ) dut (
        .clk(clk), .rst(rst), .kp(kif.master)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    logic [15:0] pressed   = 16'h0;
    logic        force_en  = 1'b1;
    logic [3:0]  force_val = 4'h0;
    always_comb begin
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (!kif.row_n[r] && pressed[r*4+k]) c[k] = 1'b0;
        kif.col_n = force_en ? force_val : c;
    end

    int n_checks = 0;
    int n_fail   = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Key event model: expected key, last confirmed index, pulse bookkeeping.
    int         cyc = 0;
    int         pulses = 0;
    int         press_cyc = 0;
    int         last_pulse_cyc = 0;
    logic       lat_armed = 1'b0;
    logic [3:0] exp_key = 4'd0;
    logic [3:0] held_idx = 4'd0;
    logic       prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            held_idx = 4'd0;
            prev_en  = 1'b0;
        end else begin
            check("row_one_hot_low", 32'($countones(~kif.row_n)), 32'd1);
            if (kif.key_en) begin
                check("pulse_key_index", 32'(kif.key_index), 32'(exp_key));
                check("pulse_not_back_to_back", 32'(prev_en), 32'd0);
                check("pulse_with_key_down", 32'(kif.key_down), 32'd1);
                if (lat_armed) begin
                    check("press_latency_in_range",
                          32'((cyc - press_cyc >= 26) && (cyc - press_cyc <= 62)), 32'd1);
                    lat_armed = 1'b0;
                end else begin
                    check("repeat_interval", 32'(cyc - last_pulse_cyc), 32'd40);
                end
                last_pulse_cyc = cyc;
                held_idx = exp_key;
                pulses++;
            end else begin
                check("key_index_held", 32'(kif.key_index), 32'(held_idx));
            end
            prev_en = kif.key_en;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        exp_key    = 4'(k);
        pressed[k] = 1'b1;
        press_cyc  = cyc;
        lat_armed  = 1'b1;
    endtask

    task automatic wait_down(input logic val, input int budget, input string name);
        int i;
        i = 0;
        while (kif.key_down !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(kif.key_down), 32'(val));
    endtask

    initial begin
        int p0;
        logic [3:0] r0;
        int i;

        // Reset with all columns pulled low.
        rst = 1'b1;
        wait_cycles(3);
        check("reset_row_n", 32'(kif.row_n), 32'b1110);
        check("reset_key_en", 32'(kif.key_en), 32'd0);
        check("reset_key_index", 32'(kif.key_index), 32'd0);
        check("reset_key_down", 32'(kif.key_down), 32'd0);
        force_val = 4'hF;
        rst = 1'b0;
        p0 = pulses;
        wait_cycles(100);
        check("idle_no_pulse", 32'(pulses - p0), 32'd0);
        force_en = 1'b0;

        // Single press of key 9.
        p0 = pulses;
        press(9);
        wait_cycles(200);
        check("single_pulse_count", 32'(pulses - p0), 32'd1);
        check("single_key_index", 32'(kif.key_index), 32'd9);
        check("single_key_down", 32'(kif.key_down), 32'd1);
        pressed = 16'h0;
        wait_cycles(5);
        check("release_not_yet_debounced", 32'(kif.key_down), 32'd1);
        wait_down(1'b0, 100, "single_release_done");

        // Bouncing key 5, then a stable hold.
        p0 = pulses;
        exp_key = 4'd5;
        for (int b = 0; b < 6; b++) begin
            pressed[5] = ~pressed[5];
            wait_cycles(10);
        end
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        press(5);
        wait_cycles(200);
        check("bounce_pulse_count", 32'(pulses - p0), 32'd1);
        check("bounce_key_index", 32'(kif.key_index), 32'd5);
        pressed = 16'h0;
        wait_down(1'b0, 100, "bounce_release_done");

        // Two columns low on row 0: lowest column wins.
        p0 = pulses;
        press(1);
        pressed[3] = 1'b1;
        wait_cycles(200);
        check("multi_pulse_count", 32'(pulses - p0), 32'd1);
        check("multi_key_index", 32'(kif.key_index), 32'd1);
        pressed = 16'h0;
        wait_down(1'b0, 100, "multi_release_done");

        // Release glitch: one low tick during release debounce.
        p0 = pulses;
        press(6);
        wait_cycles(200);
        check("glitch_first_pulse", 32'(pulses - p0), 32'd1);
        pressed = 16'h0;
        wait_cycles(12);
        pressed[6] = 1'b1;
        wait_cycles(10);
        pressed[6] = 1'b0;
        wait_cycles(8);
        check("glitch_back_to_hold", 32'(kif.key_down), 32'd1);
        wait_down(1'b0, 200, "glitch_clean_release");
        check("glitch_no_second_pulse", 32'(pulses - p0), 32'd1);
        r0 = kif.row_n;
        i = 0;
        while (kif.row_n === r0 && i < 2*SD + 4) begin
            @(negedge clk);
            i++;
        end
        check("scan_resumes", 32'(kif.row_n != r0), 32'd1);

        // Reset mid-press aborts without a pulse.
        p0 = pulses;
        press(2);
        wait_cycles(20);
        rst = 1'b1;
        wait_cycles(2);
        pressed = 16'h0;
        rst = 1'b0;
        check("abort_row_n", 32'(kif.row_n), 32'b1110);
        check("abort_key_down", 32'(kif.key_down), 32'd0);
        check("abort_key_index", 32'(kif.key_index), 32'd0);
        wait_cycles(100);
        check("abort_no_pulse", 32'(pulses - p0), 32'd0);

        // Long hold of key 15: auto-repeat only when built in.
        p0 = pulses;
        press(15);
        i = 0;
        while (pulses == p0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("hold_first_pulse", 32'(pulses - p0), 32'd1);
        wait_cycles(170);
        check("hold_pulse_count", 32'(pulses - p0), 32'(EXP_REP_PULSES));
        check("hold_key_index", 32'(kif.key_index), 32'd15);
        pressed = 16'h0;
        wait_down(1'b0, 100, "hold_release_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: actual %0d cycles required completion", cyc);
        $fatal(1);
    end
endmodule
